// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 receive path and the downstream
// key-pattern writer.
//   ps2_state_e   : receiver frame states (IDLE, DATA, PARITY, STOP)
//   PS2_BREAK     : break-code prefix byte (8'hF0)
//   PS2_EXTENDED  : extended-code prefix byte (8'hE0)
//   odd_parity_ok : 1 when data plus parity bit carry odd parity
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK    = 8'hF0;
  localparam logic [7:0] PS2_EXTENDED = 8'hE0;

  // PS/2 frames carry odd parity over the 8 data bits and the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// ps2_filter: conditions the raw PS/2 clock pin.
//   Two-flop synchronizer, then a glitch filter that only changes its output
//   after FILTER_LEN consecutive synchronized samples disagree with it, then
//   a falling-edge detector on the filtered value.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset (filtered value resets to 1)
//   pin  : raw asynchronous PS/2 clock pin
//   fall : one-cycle pulse when the filtered clock goes 1 -> 0
module ps2_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic          filt;
  logic          filt_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      filt   <= 1'b1;
      filt_d <= 1'b1;
      cnt    <= '0;
    end else begin
      sync1  <= pin;
      sync2  <= sync1;
      filt_d <= filt;
      if (sync2 != filt) begin
        // The flip happens on the edge where the count would reach
        // FILTER_LEN, so pin-to-fall latency is FILTER_LEN+2 cycles.
        if (cnt == CW'(FILTER_LEN - 1)) begin
          filt <= ~filt;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign fall = filt_d & ~filt;

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
//   Frames 11-bit packets (start, 8 data LSB-first, parity, stop) from the
//   raw PS/2 lines and delivers each scan byte unfiltered (make, break F0,
//   extended E0 alike).
// Parameters:
//   FILTER_LEN     : stable samples needed before the filtered clock changes
//   TIMEOUT_CYCLES : idle limit in clk cycles for an incomplete frame (>= 2)
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   ps2_clk   : raw PS/2 clock pin (asynchronous)
//   ps2_data  : raw PS/2 data pin (asynchronous)
//   key       : last good scan byte, held between frames
//   key_valid : one-cycle pulse when key is updated
//   frame_err : one-cycle pulse when a frame is dropped
//   busy      : high while a frame is in progress
// Build option:
//   PS2_RX_PARITY_CHECK_EN : when defined a parity mismatch drops the frame;
//                            otherwise only the stop bit decides validity.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key,
  output logic       key_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic          fall;
  logic          data_s1;
  logic          data_s2;
  ps2_state_e    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tcnt;
  logic          timeout_hit;
  logic          frame_ok;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk (clk),
    .rst (rst),
    .pin (ps2_clk),
    .fall(fall)
  );

  // Data line: synchronizer only, sampled on the filtered clock's fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Fires on the edge where the idle count would reach TIMEOUT_CYCLES-1,
  // i.e. exactly TIMEOUT_CYCLES cycles after the last fall pulse.
  assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 2));

`ifdef PS2_RX_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (fall && state == PARITY) begin
      par_bit <= data_s2;
    end
  end

  assign frame_ok = data_s2 & odd_parity_ok(shreg, par_bit);
`else
  assign frame_ok = data_s2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tcnt      <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE || fall) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end

      if (fall) begin
        case (state)
          IDLE: begin
            if (!data_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {data_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            state <= STOP;
          end
          STOP: begin
            if (frame_ok) begin
              key       <= shreg;
              key_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && timeout_hit) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        shreg     <= '0;
        frame_err <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
`timescale 1ns/1ps
module tb_ps2_rx;

  localparam int unsigned FL = 4;    // filter length under test
  localparam int unsigned TO = 300;  // timeout cycles under test
  localparam int unsigned H  = 16;   // PS/2 half period in clk cycles

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key;
  logic       key_valid;
  logic       frame_err;
  logic       busy;

  ps2_rx #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key      (key),
    .key_valid(key_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_err;
    logic [7:0]  key;
    int unsigned at;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop;
    logic       glitch;
    logic       exp_err;
    logic [7:0] exp_key;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (key_valid || frame_err)) begin
      check("strobe_exclusive", 32'(key_valid & frame_err), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'b0, frame_err, key_valid}, 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", 32'(frame_err), 32'(e.is_err));
        check("key_value", 32'(key), 32'(e.key));
        check("strobe_cycle", cyc, e.at);
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the first nbits of a frame; returns the cycle of the last clock fall.
  task automatic send_bits(input logic [10:0] bits, input int unsigned nbits,
                           input logic glitch, input logic push, input exp_t e,
                           output int unsigned last_fall);
    exp_t ee;
    last_fall = 0;
    for (int i = 0; i < int'(nbits); i++) begin
      ps2_data = bits[i];
      if (glitch && (i == 2 || i == 6)) begin
        tick(8);
        ps2_clk = 1'b0;
        tick(FL - 1);
        ps2_clk = 1'b1;
        tick(H - 8 - (FL - 1));
      end else begin
        tick(H);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      if (push && i == int'(nbits) - 1) begin
        ee    = e;
        ee.at = cyc + FL + 3;
        exp_q.push_back(ee);
      end
      tick(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(H);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par_flip,
                                             input logic stop);
    return {stop, (~^d) ^ par_flip, d, 1'b0};
  endfunction

  initial begin
    vec_t        tbl[11];
    exp_t        e;
    int unsigned lf;
    int unsigned err_at;

    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[11];
    exp_t        e;
    int unsigned lf;
    int unsigned err_at;

    tbl[0]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C};
    tbl[1]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF0};
`ifdef PS2_RX_PARITY_CHECK_EN
    tbl[2]  = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF0};
`else
    tbl[2]  = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1C};
`endif
    tbl[3]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF0};
    tbl[4]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C};
    tbl[5]  = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C};
    tbl[6]  = '{8'h29, 1'b0, 1'b1, 1'b0, 1'b0, 8'h29};
    tbl[7]  = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
    tbl[8]  = '{8'hE0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hE0};
    tbl[9]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};

    // Reset values
    #1 rst = 1'b1;
    tick(3);
    check("reset_key", 32'(key), 0);
    check("reset_key_valid", 32'(key_valid), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    tick(H);

    // Table-driven frames
    for (int i = 0; i < 11; i++) begin
      e = '{tbl[i].exp_err, tbl[i].exp_key, 0};
      send_bits(frame_bits(tbl[i].data, tbl[i].par_flip, tbl[i].stop), 11,
                tbl[i].glitch, 1'b1, e, lf);
    end
    tick(H);
    check("idle_after_table", 32'(busy), 0);

    // Timeout: five bits then silence
    e = '{1'b0, 8'h00, 0};
    send_bits(frame_bits(8'h3C, 1'b0, 1'b1), 5, 1'b0, 1'b0, e, lf);
    check("busy_mid_frame", 32'(busy), 1);
    err_at = lf + FL + 2 + TO;
    exp_q.push_back('{1'b1, 8'hFF, err_at});
    for (int k = 0; k < int'(2 * TO) && cyc <= err_at + 1; k++) tick(1);
    check("busy_after_timeout", 32'(busy), 0);
    send_bits(frame_bits(8'h3C, 1'b0, 1'b1), 11, 1'b0, 1'b1, '{1'b0, 8'h3C, 0}, lf);
    tick(H);

    // Reset pulsed mid-frame
    send_bits(frame_bits(8'h77, 1'b0, 1'b1), 5, 1'b0, 1'b0, e, lf);
    check("busy_before_reset", 32'(busy), 1);
    rst = 1'b1;
    #2;
    check("midreset_key", 32'(key), 0);
    check("midreset_key_valid", 32'(key_valid), 0);
    check("midreset_frame_err", 32'(frame_err), 0);
    check("midreset_busy", 32'(busy), 0);
    tick(2);
    rst = 1'b0;
    tick(TO + 50);
    send_bits(frame_bits(8'h5A, 1'b0, 1'b1), 11, 1'b0, 1'b1, '{1'b0, 8'h5A, 0}, lf);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick(1);
    check("pending_expectations", 32'(exp_q.size()), 0);
    check("final_key", 32'(key), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

Receives the raw PS/2 keyboard clock/data lines, frames 11-bit device-to-host packets, and delivers each scan-code byte as `key` with a one-cycle `key_valid` strobe. It sits directly upstream of the key-pattern writer; `key_valid` drives that stage's `write_en`, and `key` drives its `key`. All scan codes are forwarded unfiltered, including make, break (`F0`) and extended (`E0`) codes; break-code handling belongs to the downstream stage.

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical synchronized samples required before the filtered PS/2 clock changes.
- `TIMEOUT_CYCLES`, default 200000: idle limit in `clk` cycles for an incomplete frame (2 ms at 100 MHz).
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-high reset.
- `ps2_clk`  input  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  input  1  raw PS/2 data pin, asynchronous.
- `key`  output  8  last good scan byte; holds its value between frames.
- `key_valid`  output  1  one-cycle pulse when `key` is updated.
- `frame_err`  output  1  one-cycle pulse on a dropped frame.
- `busy`  output  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- Reset values: `key`=8'h00, `key_valid`=0, `frame_err`=0, `busy`=0, state IDLE, bit count 0, filtered clock 1.
- Both pins pass through two flip-flops. The synchronized clock goes through a glitch filter: a counter of width $clog2(FILTER_LEN+1) increments while the sample differs from the filtered value and clears otherwise; the filtered value flips when the count reaches FILTER_LEN.
- `fall` = previous filtered & ~filtered. The FSM acts only on `fall` and samples the synchronized data on that cycle.
- FSM states:
  - IDLE: `fall` with data=0 → DATA, bit count = 0. `fall` with data=1 is ignored.
  - DATA: shift data in LSB-first (shift right, new bit into bit 7); after the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: on `fall`, the frame is good when stop bit = 1 and parity is odd (parity bit = ~^data). Good frame: `key` ← shift register, `key_valid` pulses. Bad frame: `frame_err` pulses. Either way → IDLE.
- Timeout: a counter clears on every `fall` and while in IDLE, and counts otherwise. When it reaches TIMEOUT_CYCLES-1: → IDLE, `frame_err` pulses, and the partial byte is discarded.
- `key_valid` and `frame_err` are never high in the same cycle.
- Asserting `rst` mid-frame aborts the frame with no pulse on either strobe.

## Timing
- Pin-to-`fall` latency is FILTER_LEN+2 cycles.
- `key_valid` and `frame_err` are registered and assert on the cycle after the stop-bit `fall`, i.e. FILTER_LEN+3 cycles after the stop-bit pin edge.
- `key` changes on the same cycle `key_valid` asserts.
- Bytes arrive at most every ~1 ms; no back-pressure exists, and the downstream stage must accept every pulse.

## Configuration
- `PS2_RX_PARITY_CHECK_EN` defined: a parity mismatch makes the frame bad (`frame_err`, no `key_valid`).
- Not defined: the parity bit is sampled but ignored, and only the stop bit determines frame validity.

## Structure
- Shared package `ps2_pkg`:
  - state enum (IDLE, DATA, PARITY, STOP);
  - constants PS2_BREAK = 8'hF0 and PS2_EXTENDED = 8'hE0, shared with the downstream writer.
- One sub-module, `ps2_filter`: the two-flop synchronizer, the glitch filter and the `fall` detector, instantiated for the clock line. The data line uses only its synchronizer path.

## Test plan
- Valid frame, byte 8'h1C (start 0, bits LSB-first, parity 0, stop 1, 10 kHz) → `key`=8'h1C, `key_valid` high exactly 1 cycle, FILTER_LEN+3 cycles after the stop edge.
- Frames 8'hF0 then 8'h1C back to back → two `key_valid` pulses; `key` reads F0 then 1C; `frame_err` stays 0.
- Byte 8'h1C sent with parity bit 1:
  - with `PS2_RX_PARITY_CHECK_EN` → `frame_err` pulse, no `key_valid`, `key` unchanged;
  - without it → `key_valid`, `key`=8'h1C.
- Stop bit driven 0 → `frame_err` pulse and return to IDLE; a following valid 8'h29 frame → `key`=8'h29.
- Five bits sent, then lines idle → `frame_err` exactly TIMEOUT_CYCLES cycles after the last `fall`, `busy` drops; the next valid frame is received correctly.
- Clock glitches of FILTER_LEN-1 cycles inserted during a frame → ignored and the byte decodes correctly. Separately, `rst` pulsed mid-frame → outputs return to reset values with no strobes.
